ikaopm_acc_sched: RTL and testbench

IKAOPM_ACC_SCHED -- requirements
Module: IKAOPM_acc_sched

---
 rtl/ikaopm_acc_sched_pkg.sv | 35 +++
 rtl/ikaopm_acc_sched_if.sv | 43 ++++
 rtl/ikaopm_acc_sched_cnt.sv | 43 ++++
 rtl/ikaopm_acc_sched.sv | 101 ++++++++++
 tb/tb_ikaopm_acc_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ikaopm_acc_sched_pkg.sv
// rtl/ikaopm_acc_sched_pkg.sv - slot/operator encodings, carrier table and S/H windows for the accumulator scheduler
package ikaopm_acc_sched_pkg;

    typedef enum logic [1:0] {
        OP_M1 = 2'd0,
        OP_M2 = 2'd1,
        OP_C1 = 2'd2,
        OP_C2 = 2'd3
    } op_e;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] ch;
    } slot_t;

    typedef struct packed {
        logic [1:0] rl;
        logic [2:0] alg;
    } ch_cfg_t;

    // One nibble per algorithm (ALG7 in the top nibble), bit index = operator.
    localparam logic [31:0] CARRIER_TBL = {4'b1111, 4'b1110, 4'b1110, 4'b1100,
                                           4'b1000, 4'b1000, 4'b1000, 4'b1000};

    localparam logic [4:0] FRAME_LAST = 5'd31;
    localparam logic [4:0] SH1_FIRST  = 5'd18;
    localparam logic [4:0] SH1_LAST   = 5'd21;
    localparam logic [4:0] SH2_FIRST  = 5'd2;
    localparam logic [4:0] SH2_LAST   = 5'd5;

    function automatic logic is_carrier(input logic [2:0] alg, input op_e op);
        return CARRIER_TBL[{alg, op}];
    endfunction

endpackage

// File: rtl/ikaopm_acc_sched_if.sv
// rtl/ikaopm_acc_sched_if.sv - register/strobe bundle of the scheduler; mute ports under IKAOPM_ACC_SCHED_MUTE_EN
interface ikaopm_acc_sched_if;
    logic       i_phi1_NCEN_n;
    logic       i_CYCLE_SYNC;
    logic       i_REG_WR;
    logic [2:0] i_REG_CH;
    logic [1:0] i_REG_RL;
    logic [2:0] i_REG_ALG;
    logic       i_NE_WR;
    logic       i_NE;
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
    logic       i_MUTE_WR;
    logic [7:0] i_MUTE;
`endif
    logic       o_CYCLE_12;
    logic       o_CYCLE_29;
    logic       o_CYCLE_00_16;
    logic       o_CYCLE_06_22;
    logic       o_CYCLE_01_TO_16;
    logic       o_ACC_SNDADD;
    logic [1:0] o_RL;
    logic       o_NE;
    logic       o_SH1;
    logic       o_SH2;

    modport master (
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        output i_MUTE_WR, i_MUTE,
`endif
        output i_phi1_NCEN_n, i_CYCLE_SYNC, i_REG_WR, i_REG_CH, i_REG_RL, i_REG_ALG, i_NE_WR, i_NE,
        input  o_CYCLE_12, o_CYCLE_29, o_CYCLE_00_16, o_CYCLE_06_22, o_CYCLE_01_TO_16,
        input  o_ACC_SNDADD, o_RL, o_NE, o_SH1, o_SH2
    );

    modport slave (
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        input  i_MUTE_WR, i_MUTE,
`endif
        input  i_phi1_NCEN_n, i_CYCLE_SYNC, i_REG_WR, i_REG_CH, i_REG_RL, i_REG_ALG, i_NE_WR, i_NE,
        output o_CYCLE_12, o_CYCLE_29, o_CYCLE_00_16, o_CYCLE_06_22, o_CYCLE_01_TO_16,
        output o_ACC_SNDADD, o_RL, o_NE, o_SH1, o_SH2
    );
endinterface

// File: rtl/ikaopm_acc_sched_cnt.sv
// rtl/ikaopm_acc_sched_cnt.sv - 5-bit frame counter with registered cycle decodes and S/H windows
module ikaopm_acc_sched_cnt
    import ikaopm_acc_sched_pkg::*;
(
    input  logic       i_EMUCLK,
    input  logic       i_MRST,
    input  logic       i_ce,
    input  logic       i_sync,
    output logic [4:0] o_cnt,
    output logic       o_commit,
    output logic       o_CYCLE_12,
    output logic       o_CYCLE_29,
    output logic       o_CYCLE_00_16,
    output logic       o_CYCLE_06_22,
    output logic       o_CYCLE_01_TO_16,
    output logic       o_SH1,
    output logic       o_SH2
);
    // A realign on the last cycle drops that frame's commit.
    assign o_commit = i_ce && !i_sync && (o_cnt == FRAME_LAST);

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            o_cnt            <= 5'd0;
            o_CYCLE_12       <= 1'b0;
            o_CYCLE_29       <= 1'b0;
            o_CYCLE_00_16    <= 1'b0;
            o_CYCLE_06_22    <= 1'b0;
            o_CYCLE_01_TO_16 <= 1'b0;
            o_SH1            <= 1'b0;
            o_SH2            <= 1'b0;
        end else if (i_ce) begin
            o_CYCLE_12       <= (o_cnt == 5'd12);
            o_CYCLE_29       <= (o_cnt == 5'd29);
            o_CYCLE_00_16    <= (o_cnt[3:0] == 4'd0);
            o_CYCLE_06_22    <= (o_cnt[3:0] == 4'd6);
            o_CYCLE_01_TO_16 <= (o_cnt >= 5'd1) && (o_cnt <= 5'd16);
            o_SH1            <= (o_cnt >= SH1_FIRST) && (o_cnt <= SH1_LAST);
            o_SH2            <= (o_cnt >= SH2_FIRST) && (o_cnt <= SH2_LAST);
            o_cnt            <= i_sync ? 5'd0 : o_cnt + 5'd1;
        end
    end
endmodule

// File: rtl/ikaopm_acc_sched.sv
// rtl/ikaopm_acc_sched.sv - OPM accumulator scheduler: shadow/committed channel tables; optional IKAOPM_ACC_SCHED_MUTE_EN
module ikaopm_acc_sched
    import ikaopm_acc_sched_pkg::*;
#(
    parameter logic [4:0] SLOT_OFS = 5'd0
) (
    input logic                 i_EMUCLK,
    input logic                 i_MRST,
    ikaopm_acc_sched_if.slave   bus
);
    logic       ce;
    logic       commit;
    logic [4:0] cnt;

    assign ce = !bus.i_phi1_NCEN_n;

    ikaopm_acc_sched_cnt u_cnt (
        .i_EMUCLK         (i_EMUCLK),
        .i_MRST           (i_MRST),
        .i_ce             (ce),
        .i_sync           (bus.i_CYCLE_SYNC),
        .o_cnt            (cnt),
        .o_commit         (commit),
        .o_CYCLE_12       (bus.o_CYCLE_12),
        .o_CYCLE_29       (bus.o_CYCLE_29),
        .o_CYCLE_00_16    (bus.o_CYCLE_00_16),
        .o_CYCLE_06_22    (bus.o_CYCLE_06_22),
        .o_CYCLE_01_TO_16 (bus.o_CYCLE_01_TO_16),
        .o_SH1            (bus.o_SH1),
        .o_SH2            (bus.o_SH2)
    );

    ch_cfg_t    sh_cfg  [8];
    ch_cfg_t    sh_next [8];
    ch_cfg_t    cm_cfg  [8];
    logic       sh_ne, ne_next, ne_q;
    logic       snd_q;
    logic [1:0] rl_q;
    slot_t      slot;
    ch_cfg_t    cur;
    logic       add;

    // Shadow as it will look after this edge; a write on the commit edge lands in the commit.
    always_comb begin
        sh_next = sh_cfg;
        if (bus.i_REG_WR) sh_next[bus.i_REG_CH] = {bus.i_REG_RL, bus.i_REG_ALG};
        ne_next = bus.i_NE_WR ? bus.i_NE : sh_ne;
    end

`ifdef IKAOPM_ACC_SCHED_MUTE_EN
    logic [7:0] sh_mute, cm_mute, mute_next;
    assign mute_next = bus.i_MUTE_WR ? bus.i_MUTE : sh_mute;

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            sh_mute <= 8'h00;
            cm_mute <= 8'h00;
        end else begin
            sh_mute <= mute_next;
            if (commit) cm_mute <= mute_next;
        end
    end
`endif

    always_comb begin
        slot = slot_t'(cnt - SLOT_OFS);
        cur  = cm_cfg[slot.ch];
        add  = is_carrier(cur.alg, op_e'(slot.op)) && (cur.rl != 2'b00);
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        if (cm_mute[slot.ch]) add = 1'b0;
`endif
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            for (int i = 0; i < 8; i++) begin
                sh_cfg[i] <= '0;
                cm_cfg[i] <= '0;
            end
            sh_ne <= 1'b0;
            ne_q  <= 1'b0;
            snd_q <= 1'b0;
            rl_q  <= 2'b00;
        end else begin
            sh_cfg <= sh_next;
            sh_ne  <= ne_next;
            if (commit) begin
                cm_cfg <= sh_next;
                ne_q   <= ne_next;
            end
            if (ce) begin
                snd_q <= add;
                rl_q  <= add ? cur.rl : 2'b00;
            end
        end
    end

    assign bus.o_ACC_SNDADD = snd_q;
    assign bus.o_RL         = rl_q;
    assign bus.o_NE         = ne_q;
endmodule

// File: tb/tb_ikaopm_acc_sched.sv
// tb/tb_ikaopm_acc_sched.sv - self-checking bench for ikaopm_acc_sched (covers IKAOPM_ACC_SCHED_MUTE_EN when defined)
`timescale 1ns/1ps
module tb_ikaopm_acc_sched;
    localparam int OFS = 0;

    logic i_EMUCLK = 1'b0;
    logic i_MRST;
    ikaopm_acc_sched_if bus();

    ikaopm_acc_sched #(.SLOT_OFS(5'(OFS))) dut (
        .i_EMUCLK (i_EMUCLK),
        .i_MRST   (i_MRST),
        .bus      (bus)
    );

    always #5 i_EMUCLK = ~i_EMUCLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame position, shadow and committed per-channel settings.
    int m_cnt;
    int m_rl[8], m_alg[8], c_rl[8], c_alg[8];
    bit m_ne_sh, m_ne;
    bit [7:0] m_mute_sh, c_mute;
    bit e_c12, e_c29, e_c0016, e_c0622, e_c0116, e_snd, e_sh1, e_sh2;
    int e_rl;

    function automatic int nrl(input int i);
        return (bus.i_REG_WR && int'(bus.i_REG_CH) == i) ? int'(bus.i_REG_RL) : m_rl[i];
    endfunction
    function automatic int nalg(input int i);
        return (bus.i_REG_WR && int'(bus.i_REG_CH) == i) ? int'(bus.i_REG_ALG) : m_alg[i];
    endfunction
    function automatic bit nmute_wr();
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        return bus.i_MUTE_WR;
`else
        return 1'b0;
`endif
    endfunction
    function automatic bit [7:0] nmute();
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        return bus.i_MUTE_WR ? bus.i_MUTE : m_mute_sh;
`else
        return m_mute_sh;
`endif
    endfunction
    function automatic bit exp_snd(input int n);
        int s, ch, op, alg;
        bit car;
        s = (n - OFS + 32) % 32;
        ch = s % 8;
        op = s / 8;
        alg = c_alg[ch];
        car = (op == 3) || (op == 2 && alg >= 4) || (op == 1 && alg >= 5) || (alg == 7);
        return car && (c_rl[ch] != 0) && !c_mute[ch];
    endfunction
    function automatic int exp_rl(input int n);
        return exp_snd(n) ? c_rl[((n - OFS + 32) % 32) % 8] : 0;
    endfunction

    always @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            m_cnt <= 0;
            for (int i = 0; i < 8; i++) begin
                m_rl[i] <= 0; m_alg[i] <= 0; c_rl[i] <= 0; c_alg[i] <= 0;
            end
            m_ne_sh <= 0; m_ne <= 0; m_mute_sh <= 0; c_mute <= 0;
            {e_c12, e_c29, e_c0016, e_c0622, e_c0116, e_snd, e_sh1, e_sh2} <= '0;
            e_rl <= 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                m_rl[i] <= nrl(i);
                m_alg[i] <= nalg(i);
            end
            if (bus.i_NE_WR) m_ne_sh <= bus.i_NE;
            if (nmute_wr()) m_mute_sh <= nmute();
            if (!bus.i_phi1_NCEN_n) begin
                e_c12   <= (m_cnt == 12);
                e_c29   <= (m_cnt == 29);
                e_c0016 <= (m_cnt % 16 == 0);
                e_c0622 <= (m_cnt % 16 == 6);
                e_c0116 <= (m_cnt >= 1 && m_cnt <= 16);
                e_sh1   <= (m_cnt >= 18 && m_cnt <= 21);
                e_sh2   <= (m_cnt >= 2 && m_cnt <= 5);
                e_snd   <= exp_snd(m_cnt);
                e_rl    <= exp_rl(m_cnt);
                if (m_cnt == 31 && !bus.i_CYCLE_SYNC) begin
                    for (int i = 0; i < 8; i++) begin
                        c_rl[i] <= nrl(i);
                        c_alg[i] <= nalg(i);
                    end
                    m_ne <= bus.i_NE_WR ? bus.i_NE : m_ne_sh;
                    c_mute <= nmute();
                end
                m_cnt <= bus.i_CYCLE_SYNC ? 0 : (m_cnt + 1) % 32;
            end
        end
    end

    always @(negedge i_EMUCLK) begin
        if (chk_on) begin
            check("cycle_12",       bus.o_CYCLE_12,       e_c12);
            check("cycle_29",       bus.o_CYCLE_29,       e_c29);
            check("cycle_00_16",    bus.o_CYCLE_00_16,    e_c0016);
            check("cycle_06_22",    bus.o_CYCLE_06_22,    e_c0622);
            check("cycle_01_to_16", bus.o_CYCLE_01_TO_16, e_c0116);
            check("sndadd",         bus.o_ACC_SNDADD,     e_snd);
            check("rl",             bus.o_RL,             e_rl);
            check("ne",             bus.o_NE,             m_ne);
            check("sh1",            bus.o_SH1,            e_sh1);
            check("sh2",            bus.o_SH2,            e_sh2);
        end
    end

    // Per-position write schedule: kind 1=channel reg, 2=noise enable, 3=mute mask.
    int w_kind[32], w_ch[32], w_alg[32], w_rl[32];

    task automatic apply(input int k);
        case (w_kind[k])
            1: begin
                bus.i_REG_WR = 1'b1; bus.i_REG_CH = 3'(w_ch[k]);
                bus.i_REG_ALG = 3'(w_alg[k]); bus.i_REG_RL = 2'(w_rl[k]);
            end
            2: begin bus.i_NE_WR = 1'b1; bus.i_NE = w_rl[k][0]; end
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
            3: begin bus.i_MUTE_WR = 1'b1; bus.i_MUTE = 8'(w_ch[k]); end
`endif
            default: ;
        endcase
        w_kind[k] = 0;
    endtask

    task automatic release_in();
        bus.i_REG_WR = 1'b0; bus.i_NE_WR = 1'b0; bus.i_CYCLE_SYNC = 1'b0;
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        bus.i_MUTE_WR = 1'b0;
`endif
    endtask

    task automatic sched(input int k, input int kind, input int ch, input int alg, input int rl);
        w_kind[k] = kind; w_ch[k] = ch; w_alg[k] = alg; w_rl[k] = rl;
    endtask

    task automatic frame(output logic [31:0] mask, output int rlv, output int first00);
        mask = '0; rlv = 0; first00 = 0;
        for (int k = 0; k < 32; k++) begin
            apply(k);
            @(negedge i_EMUCLK);
            release_in();
            if (k == 0) first00 = int'(bus.o_CYCLE_00_16);
            if (bus.o_ACC_SNDADD) begin
                mask[k] = 1'b1;
                rlv |= int'(bus.o_RL);
            end
        end
    endtask

    function automatic int outs_vec();
        return int'({bus.o_CYCLE_12, bus.o_CYCLE_29, bus.o_CYCLE_00_16, bus.o_CYCLE_06_22,
                     bus.o_CYCLE_01_TO_16, bus.o_ACC_SNDADD, bus.o_RL, bus.o_NE, bus.o_SH1, bus.o_SH2});
    endfunction

    logic [31:0] mask;
    int rlv, f00, c12n, c12p0, c12p1, sndn, snap;

    initial begin
        for (int k = 0; k < 32; k++) w_kind[k] = 0;
        bus.i_phi1_NCEN_n = 1'b0;
        bus.i_REG_CH = 3'd0; bus.i_REG_RL = 2'd0; bus.i_REG_ALG = 3'd0; bus.i_NE = 1'b0;
`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        bus.i_MUTE = 8'h00;
`endif
        release_in();
        i_MRST = 1'b1;
        @(negedge i_EMUCLK);
        chk_on = 1'b1;
        @(negedge i_EMUCLK);
        i_MRST = 1'b0;
        check("reset_outputs", outs_vec(), 0);

        c12n = 0; c12p0 = -1; c12p1 = -1; sndn = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge i_EMUCLK);
            if (k == 0) check("first_cycle_00_16", bus.o_CYCLE_00_16, 1);
            if (bus.o_CYCLE_12) begin
                if (c12n == 0) c12p0 = k; else c12p1 = k;
                c12n++;
            end
            if (bus.o_ACC_SNDADD) sndn++;
        end
        check("c12_pulses", c12n, 2);
        check("c12_first_pos", c12p0, 12);
        check("c12_second_pos", c12p1, 44);
        check("idle_sndadd_count", sndn, 0);

        sched(10, 1, 3, 7, 3);
        frame(mask, rlv, f00);
        check("ch3_write_frame_mask", int'(mask), 0);
        sched(5, 2, 0, 0, 1);
        sched(30, 1, 3, 7, 0);
        sched(31, 1, 0, 4, 1);
        frame(mask, rlv, f00);
        check("ch3_alg7_mask", int'(mask), 32'h08080808);
        check("ch3_alg7_rl", rlv, 3);
        frame(mask, rlv, f00);
        check("ch0_alg4_mask", int'(mask), 32'h01010000);
        check("ch0_alg4_rl", rlv, 1);
        check("ne_committed", bus.o_NE, 1);

        for (int k = 0; k <= 20; k++) begin
            if (k == 15) sched(15, 1, 5, 7, 2);
            apply(k);
            if (k == 20) bus.i_CYCLE_SYNC = 1'b1;
            @(negedge i_EMUCLK);
            release_in();
        end
        frame(mask, rlv, f00);
        check("sync_first_00_16", f00, 1);
        check("sync_no_commit_mask", int'(mask), 32'h01010000);
        frame(mask, rlv, f00);
        check("sync_commit_mask", int'(mask), 32'h21212020);
        check("sync_commit_rl", rlv, 3);

`ifdef IKAOPM_ACC_SCHED_MUTE_EN
        sched(3, 1, 3, 7, 3);
        sched(4, 3, 8'h08, 0, 0);
        frame(mask, rlv, f00);
        check("mute_pre_mask", int'(mask), 32'h21212020);
        sched(4, 3, 8'h00, 0, 0);
        frame(mask, rlv, f00);
        check("mute_active_mask", int'(mask), 32'h21212020);
        frame(mask, rlv, f00);
        check("mute_restored_mask", int'(mask), 32'h29292828);
        check("mute_restored_rl", rlv, 3);
`endif

        for (int k = 0; k < 8; k++) @(negedge i_EMUCLK);
        snap = outs_vec();
        bus.i_phi1_NCEN_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_EMUCLK);
            check("hold_frozen", outs_vec(), snap);
        end
        i_MRST = 1'b1;
        @(negedge i_EMUCLK);
        i_MRST = 1'b0;
        check("hold_reset_outputs", outs_vec(), 0);
        @(negedge i_EMUCLK);
        check("hold_after_reset", outs_vec(), 0);
        bus.i_phi1_NCEN_n = 1'b0;
        frame(mask, rlv, f00);
        check("post_reset_first_00_16", f00, 1);
        check("post_reset_mask", int'(mask), 0);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
